// File: rtl/fib_seq_engine.sv
// Two-seed additive sequence engine (Fibonacci / Lucas) with a start/busy/done
// handshake, parametrised result width and a true-term overflow flag.
module fib_seq_engine #(
  parameter int WIDTH = 32,
  parameter int N_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic [N_W-1:0]   count
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b;
  logic             a_ovf, b_ovf;
  logic [N_W-1:0]   n_q;
  logic [WIDTH:0]   sum;
  logic             last, accept, step, finish;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign last = (count == n_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: if (start) state_nxt = RUN;
      RUN:       if (last)  state_nxt = FIN;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    accept = (state != RUN) && start;
    step   = (state == RUN) && !last;
    finish = (state == RUN) && last;
  end

  // a holds term count, b the look-ahead term count+1; each carries its own
  // sticky overflow so an early overflow of b never taints the reported term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a        <= '0;
      b        <= '0;
      a_ovf    <= 1'b0;
      b_ovf    <= 1'b0;
      n_q      <= '0;
      count    <= '0;
      done     <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        n_q   <= n;
        a     <= mode ? WIDTH'(2) : '0;
        b     <= WIDTH'(1);
        a_ovf <= 1'b0;
        b_ovf <= 1'b0;
        count <= '0;
      end else if (step) begin
        a     <= b;
        b     <= sum[WIDTH-1:0];
        a_ovf <= b_ovf;
        b_ovf <= a_ovf | b_ovf | sum[WIDTH];
        count <= count + 1'b1;
      end
      if (finish) begin
        out      <= a;
        overflow <= a_ovf;
      end
    end
  end

endmodule

// File: doc/fib_seq_engine.md
Name: fib_seq_engine

Overview:
Parametrised successor to the fixed 32-bit Fibonacci counter. Computes term n of a two-seed additive sequence (Fibonacci or Lucas) on a start/busy/done handshake. Result width is parametrised, and out-of-range terms are flagged with an overflow bit. Sits as a compute leaf under the sequence-demo top level; the requester drives start and n.

Parameters:
WIDTH, 32, datapath and result width in bits (>=8)
N_W, 6, width of term index n and of the step counter (n range 0..2^N_W-1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse/level; sampled only when not busy
n  input  N_W  term index, captured with start
mode  input  1  0 = Fibonacci (seeds 0,1); 1 = Lucas (seeds 2,1); captured with start
busy  output  1  high while computing
done  output  1  one-cycle pulse when out/overflow update
out  output  WIDTH  term n modulo 2^WIDTH, held until next done
overflow  output  1  true term n >= 2^WIDTH, valid with done, held with out
count  output  N_W  current step index (debug/waveform)

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, out=0, overflow=0, count=0; internal a, b, n_q and flags cleared. rst mid-RUN aborts with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at an edge: capture n_q=n; a=seed0 (0 or 2 per mode); b=1; a_ovf=b_ovf=0; count=0; go to RUN; busy=1 from that edge.
- start while RUN is ignored; n and mode changes during RUN are ignored.
- RUN, count==n_q: out<=a, overflow<=a_ovf, done<=1 for exactly one cycle, busy<=0, go to DONE.
- RUN, count!=n_q: a<=b, b<=a+b (WIDTH-bit wrap), a_ovf<=b_ovf, b_ovf<=a_ovf|b_ovf|carry_out, count<=count+1.
- Latency: start accepted at edge k gives done high after edge k+1+n. n=0 gives done after edge k+1.
- DONE: out, overflow and count hold; done=0. Returns to RUN on start; otherwise stays. Back-to-back start in the done cycle is accepted (DONE accepts start).
- IDLE is reachable only via reset. DONE behaves as IDLE for handshake purposes.
- Overflow tracks the true term, not the look-ahead b: b overflowing one step early must not flag term n.
- out is the low WIDTH bits even when overflow=1.
- count never wraps: maximum n_q = 2^N_W-1, and count stops at n_q.

Test Plan:
1. rst=1 then release; mode=0, n=0, start one cycle -> done after 1 RUN cycle, out=0, overflow=0; repeat n=1 -> out=1, done 2 cycles after start.
2. mode=0, n=21 then n=45, WIDTH=32 -> out=10946, then out=1134903170; overflow=0; busy high exactly n+1 cycles each; single-cycle done.
3. Boundary, WIDTH=32 mode=0: n=47 -> out=2971215073, overflow=0; n=48 -> out=4807526976 mod 2^32=512559680, overflow=1. mode=1: n=46 -> 4106118243, overflow=0; n=47 -> overflow=1.
4. Lucas: mode=1, n=0 -> out=2; n=1 -> 1; n=10 -> 123.
5. Handshake: n=20 started; start pulsed with n=3 and mode toggled mid-RUN -> ignored, out=6765. start held high through done -> new run begins the cycle after done, and done pulses again.
6. Reset mid-RUN (n=45, rst asserted at step 10 between clock edges) -> all outputs 0 immediately, no done. After release, run n=2 -> out=1.
